fpu_dispatch: RTL and testbench

Coprocessor dispatcher between the darkriscv core and the `fpu` block. It recognises custom-opcode FPU instructions from the core and latches their register operands. It then drives the FPU `cs`/`func`/`ready` handshake, stalls the core until the FPU finishes, and returns the result as a single-cycle register-file write-back. It also keeps a completed-operation counter and the latency of the last operation for profiling.

---
 rtl/fpu_dispatch.sv | 134 +++++++++++++
 tb/tb_fpu_dispatch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_dispatch.sv
// fpu_dispatch
// Bridges custom-opcode FPU instructions from the darkriscv core to the fpu
// block. A matching instruction with a supported funct3 has its operands
// latched and an FPU cs/func/ready handshake started. The core is stalled
// until the FPU reports ready. The result then goes back as a one-cycle
// register-file write. An unsupported funct3 raises a one-cycle illegal pulse.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ins_valid, ins              instruction from the core
//   rs1_val, rs2_val, rd_val    core register values for rs1/rs2/rd
//   halt                        combinational core stall request
//   wb_en, wb_addr, wb_data     register-file write-back (wb_en is 1 cycle)
//   illegal                     unsupported funct3 pulse
//   fpu_cs, fpu_func            FPU chip select and function code
//   fpu_ready, fpu_rdw          FPU done and result
//   fpu_rs1, fpu_rs2, fpu_rdr   latched FPU operands
//   ops_cnt                     completed operations (wraps)
//   lat_last                    latency of the last operation (saturates)
//   state_dbg                   current FSM state, for checkers
//
// Handshake: fpu_cs rises on the issue edge and stays high until the edge
// at which fpu_ready is sampled high. At that same edge it drops, so the FPU
// never sees cs high while it is back in its idle state.
module fpu_dispatch #(
  parameter logic [6:0] OPCODE = 7'b0001011,
  parameter int         LATW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ins_valid,
  input  logic [31:0]     ins,
  input  logic [31:0]     rs1_val,
  input  logic [31:0]     rs2_val,
  input  logic [31:0]     rd_val,
  output logic            halt,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [31:0]     wb_data,
  output logic            illegal,
  output logic            fpu_cs,
  output logic [2:0]      fpu_func,
  input  logic            fpu_ready,
  output logic [31:0]     fpu_rs1,
  output logic [31:0]     fpu_rs2,
  output logic [31:0]     fpu_rdr,
  input  logic [31:0]     fpu_rdw,
  output logic [15:0]     ops_cnt,
  output logic [LATW-1:0] lat_last,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [LATW-1:0] LAT_MAX = '1;

  logic [1:0]      state;
  logic [LATW-1:0] lat_cnt;
  logic [LATW-1:0] lat_next;
  logic            match;
  logic            supported;
  logic            issue;

  assign match     = ins_valid && (ins[6:0] == OPCODE);
  assign supported = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd2);
  assign issue     = (state == S_IDLE) && match && supported;

  // The ready cycle itself is counted, so lat_last uses the incremented value.
  assign lat_next  = (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + 1'b1;

  // Halt covers the issue cycle and every WAIT cycle. It is released in WB,
  // so the core advances while the result is written back.
  assign halt      = issue || (state == S_WAIT);
  assign wb_en     = (state == S_WB) && (wb_addr != 5'd0);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fpu_cs   <= 1'b0;
      fpu_func <= 3'd0;
      fpu_rs1  <= 32'd0;
      fpu_rs2  <= 32'd0;
      fpu_rdr  <= 32'd0;
      wb_addr  <= 5'd0;
      wb_data  <= 32'd0;
      illegal  <= 1'b0;
      ops_cnt  <= 16'd0;
      lat_cnt  <= '0;
      lat_last <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (match) begin
            if (supported) begin
              fpu_rs1  <= rs1_val;
              fpu_rs2  <= rs2_val;
              fpu_rdr  <= rd_val;
              fpu_func <= ins[14:12];
              wb_addr  <= ins[11:7];
              fpu_cs   <= 1'b1;
              lat_cnt  <= '0;
              state    <= S_WAIT;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_next;
          if (fpu_ready) begin
            wb_data  <= fpu_rdw;
            fpu_cs   <= 1'b0;
            lat_last <= lat_next;
            state    <= S_WB;
          end
        end
        S_WB: begin
          // Counts every completed operation, including rd == x0.
          ops_cnt <= ops_cnt + 16'd1;
          state   <= S_IDLE;
        end
        default: begin
          fpu_cs <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: table of directed operations, hand-written
// sequences for reset and non-matching instructions, then random
// operations checked against a rule-level model of the dispatcher.
module tb_fpu_dispatch;

  localparam logic [6:0] OPC = 7'b0001011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] rs1_val, rs2_val, rd_val;
  logic        halt, wb_en, illegal, fpu_cs;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  fpu_func;
  logic        fpu_ready;
  logic [31:0] fpu_rs1, fpu_rs2, fpu_rdr, fpu_rdw;
  logic [15:0] ops_cnt;
  logic [7:0]  lat_last;
  logic [1:0]  state_dbg;

  fpu_dispatch #(.OPCODE(OPC), .LATW(8)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins(ins),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_val(rd_val),
    .halt(halt), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .fpu_cs(fpu_cs), .fpu_func(fpu_func),
    .fpu_ready(fpu_ready), .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2),
    .fpu_rdr(fpu_rdr), .fpu_rdw(fpu_rdw), .ops_cnt(ops_cnt),
    .lat_last(lat_last), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: completed-op count and last latency
  int exp_ops = 0;
  int exp_lat = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rdv;
    int          lat;
    logic [31:0] res;
    logic        exp_wb;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one instruction starting at a negedge and follows it to IDLE.
  // Returns at the negedge of the first IDLE cycle after the operation.
  task automatic run_op(input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] rdv, input int lat,
                        input logic [31:0] res, input logic exp_wb,
                        input logic exp_ill, input int exp_lt);
    logic        sup;
    logic [31:0] junk;
    sup = (f3 == 3'd1) || (f3 == 3'd2);
    ins_valid = 1'b1;
    ins       = {17'd0, f3, rd, OPC};
    rs1_val   = rs1;
    rs2_val   = rs2;
    rd_val    = rdv;
    #1;
    chk("halt_issue", {31'd0, halt}, {31'd0, sup});
    @(posedge clk);
    @(negedge clk);
    if (!sup) begin
      ins_valid = 1'b0;
      chk("illegal_pulse", {31'd0, illegal}, {31'd0, exp_ill});
      chk("illegal_halt", {31'd0, halt}, 32'd0);
      chk("illegal_cs", {31'd0, fpu_cs}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("illegal_once", {31'd0, illegal}, 32'd0);
      chk("illegal_wb", {31'd0, wb_en}, 32'd0);
    end else begin
      for (int k = 1; k <= lat; k++) begin
        // core inputs change while halted: must be ignored
        junk = $urandom();
        junk[6:0] = OPC;
        junk[14:12] = 3'd1;
        ins       = junk;
        ins_valid = 1'b1;
        rs1_val   = $urandom();
        rs2_val   = $urandom();
        rd_val    = $urandom();
        chk("wait_cs", {31'd0, fpu_cs}, 32'd1);
        chk("wait_halt", {31'd0, halt}, 32'd1);
        chk("wait_wb", {31'd0, wb_en}, 32'd0);
        if (k == 1 || k == lat) begin
          chk("op_func", {29'd0, fpu_func}, {29'd0, f3});
          chk("op_rs1", fpu_rs1, rs1);
          chk("op_rs2", fpu_rs2, rs2);
          chk("op_rdr", fpu_rdr, rdv);
        end
        fpu_ready = (k == lat);
        fpu_rdw   = (k == lat) ? res : $urandom();
        @(posedge clk);
        @(negedge clk);
      end
      // WB cycle
      fpu_ready = 1'b0;
      fpu_rdw   = $urandom();
      ins_valid = 1'b0;
      #1;
      chk("wb_cs_low", {31'd0, fpu_cs}, 32'd0);
      chk("wb_halt", {31'd0, halt}, 32'd0);
      chk("wb_en", {31'd0, wb_en}, {31'd0, exp_wb});
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, rd});
      chk("wb_data", wb_data, res);
      chk("lat_last", {24'd0, lat_last}, exp_lt[31:0]);
      chk("wb_illegal", {31'd0, illegal}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("post_wb_en", {31'd0, wb_en}, 32'd0);
      chk("post_cs", {31'd0, fpu_cs}, 32'd0);
    end
    chk("ops_cnt", {16'd0, ops_cnt}, exp_ops[31:0]);
  endtask

  // Rule-level model: what an operation should produce.
  task automatic model_op(input logic [2:0] f3, input logic [4:0] rd, input int lat,
                          output logic wb, output logic ill, output int lt);
    logic sup;
    sup = (f3 == 3'd1) || (f3 == 3'd2);
    wb  = sup && (rd != 5'd0);
    ill = !sup;
    if (sup) begin
      exp_lat = (lat > 255) ? 255 : lat;
      exp_ops = (exp_ops + 1) % 65536;
    end
    lt = exp_lat;
  endtask

  initial begin
    logic        wb, ill;
    int          lt;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          lat;

    vecs[0] = '{3'd1, 5'd5,  32'h40400000, 32'h3F800000, 32'h00000000, 5,   32'h40800000, 1'b1, 1'b0, 5};
    vecs[1] = '{3'd2, 5'd7,  32'h40000000, 32'h3F800000, 32'h3F800000, 3,   32'h40000000, 1'b1, 1'b0, 3};
    vecs[2] = '{3'd3, 5'd9,  32'h11111111, 32'h22222222, 32'h33333333, 4,   32'h0,        1'b0, 1'b1, 3};
    vecs[3] = '{3'd1, 5'd0,  32'h40A00000, 32'h40400000, 32'h00000000, 1,   32'h40800000, 1'b0, 1'b0, 1};
    vecs[4] = '{3'd0, 5'd4,  32'h0,        32'h0,        32'h0,        2,   32'h0,        1'b0, 1'b1, 1};
    vecs[5] = '{3'd2, 5'd31, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 300, 32'h5A5A5A5A, 1'b1, 1'b0, 255};
    vecs[6] = '{3'd7, 5'd1,  32'h0,        32'h0,        32'h0,        2,   32'h0,        1'b0, 1'b1, 255};

    rst_n     = 1'b0;
    ins_valid = 1'b0;
    ins       = 32'd0;
    rs1_val   = 32'd0;
    rs2_val   = 32'd0;
    rd_val    = 32'd0;
    fpu_ready = 1'b0;
    fpu_rdw   = 32'd0;
    #1;
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_cs", {31'd0, fpu_cs}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_func", {29'd0, fpu_func}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_rs1", fpu_rs1, 32'd0);
    chk("rst_rs2", fpu_rs2, 32'd0);
    chk("rst_rdr", fpu_rdr, 32'd0);
    chk("rst_ops", {16'd0, ops_cnt}, 32'd0);
    chk("rst_lat", {24'd0, lat_last}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven directed operations, issued back to back
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].f3 == 3'd1 || vecs[i].f3 == 3'd2) exp_ops++;
      run_op(vecs[i].f3, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].rdv,
             vecs[i].lat, vecs[i].res, vecs[i].exp_wb, vecs[i].exp_ill, vecs[i].exp_lat);
    end
    exp_lat = 255;

    // non-matching opcode is not ours: no stall, no pulse, no select
    ins_valid = 1'b1;
    ins       = 32'h0000_1033;
    #1;
    chk("other_halt", {31'd0, halt}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    chk("other_cs", {31'd0, fpu_cs}, 32'd0);
    chk("other_illegal", {31'd0, illegal}, 32'd0);

    // reset in the middle of WAIT
    ins_valid = 1'b1;
    ins       = {17'd0, 3'd1, 5'd9, OPC};
    rs1_val   = 32'h1;
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_wait_cs", {31'd0, fpu_cs}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cs", {31'd0, fpu_cs}, 32'd0);
    chk("async_halt", {31'd0, halt}, 32'd0);
    chk("async_wb", {31'd0, wb_en}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ops = 0;
    exp_lat = 0;
    chk("rst2_ops", {16'd0, ops_cnt}, 32'd0);
    chk("rst2_lat", {24'd0, lat_last}, 32'd0);
    chk("rst2_wb_data", wb_data, 32'd0);
    chk("rst2_halt", {31'd0, halt}, 32'd0);
    exp_ops = 1;
    run_op(3'd2, 5'd12, 32'h3F800000, 32'h0, 32'h40000000, 4, 32'h40400000, 1'b1, 1'b0, 4);
    exp_lat = 4;

    // random operations against the model
    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 31));
      lat = $urandom_range(1, 12);
      model_op(f3, rd, lat, wb, ill, lt);
      run_op(f3, rd, $urandom(), $urandom(), $urandom(), lat, $urandom(), wb, ill, lt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
